hazard_controller: RTL and testbench

- Produces the per-stage stall/flush controls consumed by the pipeline registers (pr_i2d, pr_d2e, pr_e2m, pr_m2w), plus the fetch-stage stall and the PC redirect.
- Resolves d-cache miss, branch misprediction, load-use and i-cache miss hazards with a fixed priority.
- Holds a pending redirect until an in-flight i-cache fill completes.
- Keeps saturating performance counters per hazard cause.

---
 rtl/mips_core_pkg.sv | 18 +
 rtl/hazard_controller_sat_counter.sv | 25 ++
 rtl/hazard_controller.sv | 182 ++++++++++++++++++
 tb/tb_hazard_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared types for the MIPS core hazard logic: controller states and the
// hazard cause codes used by the priority encoder (also handy for debug).
package mips_core_pkg;

  typedef enum logic {
    IDLE,
    WAIT_IFILL
  } hazard_state_t;

  typedef enum logic [2:0] {
    NONE,
    DMISS,
    MISPRED,
    LOADUSE,
    IMISS
  } hazard_cause_t;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter used for the hazard performance statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc_i,
  output logic [COUNT_W-1:0] count_o
);

  logic [COUNT_W-1:0] count_q;

  // Count one event per cycle until the counter is full, then hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: prioritises d-cache miss, branch mispredict,
// load-use and i-cache miss hazards into per-stage stall/flush controls and a
// PC redirect. A redirect raised during an i-cache fill is parked until the
// fill completes. Per-cause saturating counters track hazard activity.
module hazard_controller
  import mips_core_pkg::*;
#(
  parameter int COUNT_W = 32,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_icache_miss,
  input  logic               i_dcache_miss,
  input  logic               i_dec_uses_rs,
  input  logic [4:0]         i_dec_rs_addr,
  input  logic               i_dec_uses_rt,
  input  logic [4:0]         i_dec_rt_addr,
  input  logic               i_ex_is_load,
  input  logic [4:0]         i_ex_rw_addr,
  input  logic               i_ex_branch_valid,
  input  logic               i_ex_mispredict,
  input  logic [ADDR_W-1:0]  i_ex_recovery_target,
  output logic               o_if_stall,
  output logic               o_redirect_valid,
  output logic [ADDR_W-1:0]  o_redirect_pc,
  output logic               o_i2d_stall,
  output logic               o_i2d_flush,
  output logic               o_d2e_stall,
  output logic               o_d2e_flush,
  output logic               o_e2m_stall,
  output logic               o_e2m_flush,
  output logic               o_m2w_stall,
  output logic               o_m2w_flush,
  output logic [COUNT_W-1:0] o_cnt_dmiss,
  output logic [COUNT_W-1:0] o_cnt_loaduse,
  output logic [COUNT_W-1:0] o_cnt_mispredict
);

  hazard_state_t     state_q, state_d;
  logic [ADDR_W-1:0] target_q, target_d;
  hazard_cause_t     cause;
  logic              loaduse;
  logic              mispred;
  logic              incDmiss;
  logic              incLoaduse;
  logic              incMispred;

  // Raw hazard detection; register 0 is hardwired so it never creates a dependency.
  always_comb begin
    loaduse = i_ex_is_load && (i_ex_rw_addr != 5'd0) &&
              ((i_dec_uses_rs && (i_dec_rs_addr == i_ex_rw_addr)) ||
               (i_dec_uses_rt && (i_dec_rt_addr == i_ex_rw_addr)));
    mispred = i_ex_branch_valid && i_ex_mispredict;
  end

  // Fixed-priority hazard resolution producing controls and next state.
  // Everything is forced quiet while reset is held.
  always_comb begin
    state_d          = state_q;
    target_d         = target_q;
    cause            = NONE;
    incDmiss         = 1'b0;
    incLoaduse       = 1'b0;
    incMispred       = 1'b0;
    o_if_stall       = 1'b0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    o_i2d_stall      = 1'b0;
    o_i2d_flush      = 1'b0;
    o_d2e_stall      = 1'b0;
    o_d2e_flush      = 1'b0;
    o_e2m_stall      = 1'b0;
    o_e2m_flush      = 1'b0;
    o_m2w_stall      = 1'b0;
    o_m2w_flush      = 1'b0;

    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (i_dcache_miss)      cause = DMISS;
          else if (mispred)       cause = MISPRED;
          else if (loaduse)       cause = LOADUSE;
          else if (i_icache_miss) cause = IMISS;
          else                    cause = NONE;

          case (cause)
            DMISS: begin
              o_if_stall  = 1'b1;
              o_i2d_stall = 1'b1;
              o_d2e_stall = 1'b1;
              o_e2m_stall = 1'b1;
              o_m2w_flush = 1'b1;
              incDmiss    = 1'b1;
            end
            MISPRED: begin
              o_i2d_flush = 1'b1;
              o_d2e_flush = 1'b1;
              incMispred  = 1'b1;
              if (!i_icache_miss) begin
                o_redirect_valid = 1'b1;
                o_redirect_pc    = i_ex_recovery_target;
              end else begin
                o_if_stall = 1'b1;
                target_d   = i_ex_recovery_target;
                state_d    = WAIT_IFILL;
              end
            end
            LOADUSE: begin
              o_if_stall  = 1'b1;
              o_i2d_stall = 1'b1;
              o_d2e_flush = 1'b1;
              incLoaduse  = 1'b1;
            end
            IMISS: begin
              o_if_stall  = 1'b1;
              o_i2d_flush = 1'b1;
            end
            default: begin
            end
          endcase
        end

        WAIT_IFILL: begin
          if (i_dcache_miss) begin
            o_if_stall  = 1'b1;
            o_i2d_flush = 1'b1;
            o_d2e_stall = 1'b1;
            o_e2m_stall = 1'b1;
            o_m2w_flush = 1'b1;
            incDmiss    = 1'b1;
          end else if (i_icache_miss) begin
            o_if_stall  = 1'b1;
            o_i2d_flush = 1'b1;
          end else begin
            o_redirect_valid = 1'b1;
            o_redirect_pc    = target_q;
            o_i2d_flush      = 1'b1;
            state_d          = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Controller state and the parked redirect target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  sat_counter #(.COUNT_W(COUNT_W)) u_cnt_dmiss (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (incDmiss),
    .count_o (o_cnt_dmiss)
  );

  sat_counter #(.COUNT_W(COUNT_W)) u_cnt_loaduse (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (incLoaduse),
    .count_o (o_cnt_loaduse)
  );

  sat_counter #(.COUNT_W(COUNT_W)) u_cnt_mispredict (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (incMispred),
    .count_o (o_cnt_mispredict)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller. Counters are built 4 bits wide
// so saturation is reachable quickly.
module tb_hazard_controller;

  localparam int COUNT_W = 4;
  localparam int ADDR_W  = 32;

  // Control vector order: if_stall, redirect_valid, i2d s/f, d2e s/f, e2m s/f, m2w s/f
  localparam logic [9:0] C_NONE  = 10'b0000000000;
  localparam logic [9:0] C_LU    = 10'b1010010000;
  localparam logic [9:0] C_DM    = 10'b1010101001;
  localparam logic [9:0] C_DMW   = 10'b1001101001;
  localparam logic [9:0] C_RED   = 10'b0101010000;
  localparam logic [9:0] C_MWAIT = 10'b1001010000;
  localparam logic [9:0] C_IM    = 10'b1001000000;
  localparam logic [9:0] C_REDW  = 10'b0101000000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_icache_miss;
  logic               i_dcache_miss;
  logic               i_dec_uses_rs;
  logic [4:0]         i_dec_rs_addr;
  logic               i_dec_uses_rt;
  logic [4:0]         i_dec_rt_addr;
  logic               i_ex_is_load;
  logic [4:0]         i_ex_rw_addr;
  logic               i_ex_branch_valid;
  logic               i_ex_mispredict;
  logic [ADDR_W-1:0]  i_ex_recovery_target;
  logic               o_if_stall;
  logic               o_redirect_valid;
  logic [ADDR_W-1:0]  o_redirect_pc;
  logic               o_i2d_stall, o_i2d_flush;
  logic               o_d2e_stall, o_d2e_flush;
  logic               o_e2m_stall, o_e2m_flush;
  logic               o_m2w_stall, o_m2w_flush;
  logic [COUNT_W-1:0] o_cnt_dmiss;
  logic [COUNT_W-1:0] o_cnt_loaduse;
  logic [COUNT_W-1:0] o_cnt_mispredict;
  logic [9:0]         ctl;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_controller #(.COUNT_W(COUNT_W), .ADDR_W(ADDR_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_icache_miss        (i_icache_miss),
    .i_dcache_miss        (i_dcache_miss),
    .i_dec_uses_rs        (i_dec_uses_rs),
    .i_dec_rs_addr        (i_dec_rs_addr),
    .i_dec_uses_rt        (i_dec_uses_rt),
    .i_dec_rt_addr        (i_dec_rt_addr),
    .i_ex_is_load         (i_ex_is_load),
    .i_ex_rw_addr         (i_ex_rw_addr),
    .i_ex_branch_valid    (i_ex_branch_valid),
    .i_ex_mispredict      (i_ex_mispredict),
    .i_ex_recovery_target (i_ex_recovery_target),
    .o_if_stall           (o_if_stall),
    .o_redirect_valid     (o_redirect_valid),
    .o_redirect_pc        (o_redirect_pc),
    .o_i2d_stall          (o_i2d_stall),
    .o_i2d_flush          (o_i2d_flush),
    .o_d2e_stall          (o_d2e_stall),
    .o_d2e_flush          (o_d2e_flush),
    .o_e2m_stall          (o_e2m_stall),
    .o_e2m_flush          (o_e2m_flush),
    .o_m2w_stall          (o_m2w_stall),
    .o_m2w_flush          (o_m2w_flush),
    .o_cnt_dmiss          (o_cnt_dmiss),
    .o_cnt_loaduse        (o_cnt_loaduse),
    .o_cnt_mispredict     (o_cnt_mispredict)
  );

  // Pack the stage controls into one vector for compact comparisons.
  assign ctl = {o_if_stall, o_redirect_valid, o_i2d_stall, o_i2d_flush,
                o_d2e_stall, o_d2e_flush, o_e2m_stall, o_e2m_flush,
                o_m2w_stall, o_m2w_flush};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and settle the outputs.
  // lu builds a load-use on r5 via rs; mis raises a resolved mispredict.
  task automatic applyStimulus(input logic rst, input logic dmiss, input logic imiss,
                               input logic mis, input logic lu,
                               input logic [31:0] tgt);
    @(negedge clk);
    rst_n                = rst;
    i_dcache_miss        = dmiss;
    i_icache_miss        = imiss;
    i_ex_branch_valid    = mis;
    i_ex_mispredict      = mis;
    i_ex_recovery_target = tgt;
    i_ex_is_load         = lu;
    i_ex_rw_addr         = lu ? 5'd5 : 5'd0;
    i_dec_uses_rs        = lu;
    i_dec_rs_addr        = lu ? 5'd5 : 5'd0;
    i_dec_uses_rt        = 1'b0;
    i_dec_rt_addr        = 5'd0;
    #1;
  endtask

  initial begin
    // Reset held with every input high.
    rst_n                = 1'b0;
    i_icache_miss        = 1'b1;
    i_dcache_miss        = 1'b1;
    i_dec_uses_rs        = 1'b1;
    i_dec_rs_addr        = 5'h1f;
    i_dec_uses_rt        = 1'b1;
    i_dec_rt_addr        = 5'h1f;
    i_ex_is_load         = 1'b1;
    i_ex_rw_addr         = 5'h1f;
    i_ex_branch_valid    = 1'b1;
    i_ex_mispredict      = 1'b1;
    i_ex_recovery_target = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("rst_ctl", 32'(ctl), 32'(C_NONE));
      checkOutput("rst_pc", o_redirect_pc, 32'h0);
      checkOutput("rst_cnt", 32'({o_cnt_dmiss, o_cnt_loaduse, o_cnt_mispredict}), 32'h0);
    end

    // Release with idle inputs.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 32'h0);
      checkOutput("idle_ctl", 32'(ctl), 32'(C_NONE));
      checkOutput("idle_cnt", 32'({o_cnt_dmiss, o_cnt_loaduse, o_cnt_mispredict}), 32'h0);
    end

    // Load-use on r5, then the same pattern on r0.
    applyStimulus(1, 0, 0, 0, 1, 32'h0);
    checkOutput("lu_ctl", 32'(ctl), 32'(C_LU));
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    checkOutput("lu_cnt", 32'(o_cnt_loaduse), 32'd1);
    checkOutput("lu_after_ctl", 32'(ctl), 32'(C_NONE));
    applyStimulus(1, 0, 0, 0, 1, 32'h0);
    i_ex_rw_addr  = 5'd0;
    i_dec_rs_addr = 5'd0;
    #1;
    checkOutput("lu_r0_ctl", 32'(ctl), 32'(C_NONE));
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    checkOutput("lu_r0_cnt", 32'(o_cnt_loaduse), 32'd1);

    // D-cache miss overrides a simultaneous mispredict and load-use.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 1, 1, 32'h0040_0100);
      checkOutput("dm_ctl", 32'(ctl), 32'(C_DM));
      checkOutput("dm_pc", o_redirect_pc, 32'h0);
    end
    applyStimulus(1, 0, 0, 1, 0, 32'h0040_0100);
    checkOutput("dm_cnt", 32'(o_cnt_dmiss), 32'd4);
    checkOutput("mp_ctl", 32'(ctl), 32'(C_RED));
    checkOutput("mp_pc", o_redirect_pc, 32'h0040_0100);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    checkOutput("mp_cnt", 32'(o_cnt_mispredict), 32'd1);
    checkOutput("mp_noleft_ctl", 32'(ctl), 32'(C_NONE));

    // Mispredict during an i-cache fill: redirect parked until the fill ends.
    applyStimulus(1, 0, 1, 1, 0, 32'h0040_0200);
    checkOutput("wf0_ctl", 32'(ctl), 32'(C_MWAIT));
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1, 0, 1, 0, (i == 2), 32'h0);
      checkOutput("wf_ctl", 32'(ctl), 32'(C_IM));
      checkOutput("wf_pc", o_redirect_pc, 32'h0);
    end
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    checkOutput("wf4_ctl", 32'(ctl), 32'(C_REDW));
    checkOutput("wf4_pc", o_redirect_pc, 32'h0040_0200);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    checkOutput("wf5_ctl", 32'(ctl), 32'(C_NONE));
    checkOutput("wf_mp_cnt", 32'(o_cnt_mispredict), 32'd2);
    checkOutput("wf_lu_cnt", 32'(o_cnt_loaduse), 32'd1);

    // Parked redirect held back by a d-cache miss.
    applyStimulus(1, 0, 1, 1, 0, 32'h0040_0300);
    checkOutput("wd0_ctl", 32'(ctl), 32'(C_MWAIT));
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 0, 0, 0, 32'h0);
      checkOutput("wd_ctl", 32'(ctl), 32'(C_DMW));
      checkOutput("wd_pc", o_redirect_pc, 32'h0);
    end
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    checkOutput("wd_red_ctl", 32'(ctl), 32'(C_REDW));
    checkOutput("wd_red_pc", o_redirect_pc, 32'h0040_0300);
    checkOutput("wd_dm_cnt", 32'(o_cnt_dmiss), 32'd6);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    checkOutput("wd_idle_ctl", 32'(ctl), 32'(C_NONE));
    checkOutput("wd_mp_cnt", 32'(o_cnt_mispredict), 32'd3);

    // Reset while a redirect is parked discards it.
    applyStimulus(1, 0, 1, 1, 0, 32'h0040_0400);
    checkOutput("wr0_ctl", 32'(ctl), 32'(C_MWAIT));
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("wr_rst_ctl", 32'(ctl), 32'(C_NONE));
    checkOutput("wr_rst_pc", o_redirect_pc, 32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 32'h0);
      checkOutput("wr_ctl", 32'(ctl), 32'(C_NONE));
      checkOutput("wr_pc", o_redirect_pc, 32'h0);
    end
    checkOutput("wr_cnt", 32'({o_cnt_dmiss, o_cnt_loaduse, o_cnt_mispredict}), 32'h0);

    // Saturation of the 4-bit d-cache miss counter.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1, 0, 0, 0, 32'h0);
      if (i == 15) checkOutput("sat_15", 32'(o_cnt_dmiss), 32'd15);
    end
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    checkOutput("sat_end", 32'(o_cnt_dmiss), 32'd15);
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    checkOutput("sat_hold", 32'(o_cnt_dmiss), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
